// File: rtl/sort_pkg.sv
//------------------------------------------------------------------------------
// sort_pkg : colour codes, FSM state encodings and helpers for the sort sequencer
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sort_pkg;

    localparam logic [2:0] COL_RED     = 3'd0;
    localparam logic [2:0] COL_BLUE    = 3'd1;
    localparam logic [2:0] COL_GREEN   = 3'd2;
    localparam logic [2:0] COL_YELLOW  = 3'd3;
    localparam logic [2:0] COL_UNKNOWN = 3'd4;
    localparam int         NUM_COLOURS = 5;

    typedef logic [2:0] state_t;
    localparam state_t IDLE    = 3'd0;
    localparam state_t SETTLE  = 3'd1;
    localparam state_t MEASURE = 3'd2;
    localparam state_t ROUTE   = 3'd3;
    localparam state_t RELEASE = 3'd4;

    // Codes 5..7 carry no colour meaning and are folded into unknown.
    function automatic logic [2:0] sanitise_code(input logic [2:0] c);
        return (c > COL_UNKNOWN) ? COL_UNKNOWN : c;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sort_stats.sv
//------------------------------------------------------------------------------
// sort_stats : total and per-colour item counters (saturating with SORT_SAT_COUNT_EN)
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sort_stats
    import sort_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc,
    input  logic [2:0]                   colour,
    output logic [CNT_W-1:0]             total_count,
    output logic [NUM_COLOURS*CNT_W-1:0] count_flat
);

    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] col_q [NUM_COLOURS];
    logic [CNT_W-1:0] col_d [NUM_COLOURS];

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef SORT_SAT_COUNT_EN
        return (&v) ? v : v + CNT_W'(1);
`else
        return v + CNT_W'(1);
`endif
    endfunction

    always_comb begin
        total_d = total_q;
        for (int k = 0; k < NUM_COLOURS; k++) begin
            col_d[k] = col_q[k];
            if (inc && (colour == 3'(k))) begin
                col_d[k] = bump(col_q[k]);
            end
        end
        if (inc) begin
            total_d = bump(total_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_q <= '0;
            for (int k = 0; k < NUM_COLOURS; k++) begin
                col_q[k] <= '0;
            end
        end else begin
            total_q <= total_d;
            for (int k = 0; k < NUM_COLOURS; k++) begin
                col_q[k] <= col_d[k];
            end
        end
    end

    assign total_count = total_q;

    for (genvar k = 0; k < NUM_COLOURS; k++) begin : g_col
        assign count_flat[k*CNT_W +: CNT_W] = col_q[k];
    end

endmodule

`default_nettype wire

// File: rtl/sort_sequencer.sv
//------------------------------------------------------------------------------
// sort_sequencer : settle / measure / route / release scheduler for one item.
// Optional macro SORT_SAT_COUNT_EN makes the statistics counters saturate.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sort_sequencer
    import sort_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 4000000,
    parameter int GATE_CYCLES    = 500000,
    parameter int CNT_W          = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         item_present,
    input  logic                         color_done,
    input  logic [2:0]                   color_code,
    output logic                         color_run,
    output logic [2:0]                   bin_sel,
    output logic                         gate_open,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [CNT_W-1:0]             total_count,
    output logic [NUM_COLOURS*CNT_W-1:0] count_flat
);

    localparam int MAX_CYC = max3(SETTLE_CYCLES, TIMEOUT_CYCLES, GATE_CYCLES);
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST    = TMR_W'(GATE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       code_q, code_d;
    logic             terr_q, terr_d;
    logic             stats_inc;
    logic             item_s;

    assign item_s = sync_q[1];

    always_comb begin
        sync_d    = {sync_q[0], item_present};
        state_d   = state_q;
        timer_d   = timer_q + TMR_W'(1);
        code_d    = code_q;
        terr_d    = terr_q;
        stats_inc = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (item_s) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!item_s) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = MEASURE;
                    timer_d = '0;
                end
            end
            MEASURE: begin
                // A done arriving on the timeout cycle still counts as a result.
                if (color_done) begin
                    code_d  = sanitise_code(color_code);
                    state_d = ROUTE;
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    terr_d  = 1'b1;
                    code_d  = COL_UNKNOWN;
                    state_d = ROUTE;
                    timer_d = '0;
                end
            end
            ROUTE: begin
                if (timer_q == GATE_LAST) begin
                    stats_inc = 1'b1;
                    state_d   = RELEASE;
                    timer_d   = '0;
                end
            end
            RELEASE: begin
                timer_d = '0;
                if (!item_s && !color_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= IDLE;
            timer_q <= '0;
            code_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            terr_q  <= terr_d;
        end
    end

    assign color_run   = (state_q == MEASURE);
    assign gate_open   = (state_q == ROUTE);
    assign busy        = (state_q != IDLE);
    assign bin_sel     = code_q;
    assign timeout_err = terr_q;

    sort_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (stats_inc),
        .colour     (code_q),
        .total_count(total_count),
        .count_flat (count_flat)
    );

endmodule

`default_nettype wire

// File: tb/tb_sort_sequencer.sv
//------------------------------------------------------------------------------
// tb_sort_sequencer : directed, table-driven bench for sort_sequencer
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sort_sequencer;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 20;
    localparam int GATE    = 3;
    localparam int CW      = 4;

    logic          clk;
    logic          rst_n;
    logic          item_present;
    logic          color_done;
    logic [2:0]    color_code;
    logic          color_run;
    logic [2:0]    bin_sel;
    logic          gate_open;
    logic          busy;
    logic          timeout_err;
    logic [CW-1:0] total_count;
    logic [5*CW-1:0] count_flat;

    int n_cmp;
    int n_fail;

    sort_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .GATE_CYCLES   (GATE),
        .CNT_W         (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .item_present(item_present),
        .color_done  (color_done),
        .color_code  (color_code),
        .color_run   (color_run),
        .bin_sel     (bin_sel),
        .gate_open   (gate_open),
        .busy        (busy),
        .timeout_err (timeout_err),
        .total_count (total_count),
        .count_flat  (count_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        int         done_at;   // MEASURE cycle on which done is seen, 0 = never
        int         exp_bin;
        int         exp_terr;
        int         exp_total;
        int         exp_cnt;   // count of colour exp_bin after this item
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int colour_cnt(input int idx);
        logic [5*CW-1:0] f;
        f = count_flat;
        return int'(f[idx*CW +: CW]);
    endfunction

    // Drives one complete item and checks every phase of its handling.
    task automatic run_item(input vec_t v, input bit full);
        int cnt;
        int rcnt;
        int gcnt;
        item_present = 1'b1;
        color_code   = v.code;
        cnt = 0;
        while (!color_run && cnt < 50) begin
            tick();
            cnt++;
        end
        if (full) check("run_latency", cnt, SETTLE + 3);
        rcnt = 0;
        while (color_run && rcnt < 100) begin
            if (v.done_at != 0 && rcnt == v.done_at - 1) color_done = 1'b1;
            tick();
            rcnt++;
        end
        if (full) check("run_length", rcnt, (v.done_at != 0) ? v.done_at : TIMEOUT);
        check("gate_rise", int'(gate_open), 1);
        check("bin_sel", int'(bin_sel), v.exp_bin);
        gcnt = 0;
        while (gate_open && gcnt < 50) begin
            gcnt++;
            tick();
        end
        if (full) check("gate_len", gcnt, GATE);
        item_present = 1'b0;
        color_done   = 1'b0;
        cnt = 0;
        while (busy && cnt < 20) begin
            tick();
            cnt++;
        end
        check("release_idle", int'(busy), 0);
        check("timeout_err", int'(timeout_err), v.exp_terr);
        check("total_count", int'(total_count), v.exp_total);
        check("colour_count", colour_cnt(v.exp_bin), v.exp_cnt);
    endtask

    vec_t vecs[7];

    initial begin
        int cnt;
        int seen_run;
        int exp_n;
        vec_t red;

        vecs[0] = '{3'd2, 5,  2, 0, 1, 1};
        vecs[1] = '{3'd6, 3,  4, 0, 2, 1};
        vecs[2] = '{3'd0, 20, 0, 0, 3, 1};
        vecs[3] = '{3'd3, 1,  3, 0, 4, 1};
        vecs[4] = '{3'd1, 0,  4, 1, 5, 2};
        vecs[5] = '{3'd1, 2,  1, 1, 6, 1};
        vecs[6] = '{3'd7, 1,  4, 1, 7, 3};

        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        item_present = 1'b0;
        color_done = 1'b0;
        color_code = 3'd0;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_run", int'(color_run), 0);
        check("rst_gate", int'(gate_open), 0);
        check("rst_bin", int'(bin_sel), 0);
        check("rst_terr", int'(timeout_err), 0);
        check("rst_total", int'(total_count), 0);
        check("rst_flat", int'(count_flat), 0);
        rst_n = 1'b1;
        tick();

        // done outside MEASURE must not start anything
        color_done = 1'b1;
        tick();
        tick();
        check("done_idle_busy", int'(busy), 0);
        color_done = 1'b0;

        // short glitch on the sensor
        item_present = 1'b1;
        seen_run = 0;
        tick();
        tick();
        item_present = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (color_run) seen_run = 1;
            tick();
        end
        check("glitch_run", seen_run, 0);
        check("glitch_busy", int'(busy), 0);

        for (int i = 0; i < 7; i++) begin
            run_item(vecs[i], 1'b1);
        end

        // reset while the gate is open
        item_present = 1'b1;
        color_code = 3'd3;
        cnt = 0;
        while (!color_run && cnt < 50) begin
            tick();
            cnt++;
        end
        color_done = 1'b1;
        tick();
        check("pre_rst_gate", int'(gate_open), 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_gate", int'(gate_open), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_run", int'(color_run), 0);
        check("mid_rst_terr", int'(timeout_err), 0);
        check("mid_rst_total", int'(total_count), 0);
        check("mid_rst_flat", int'(count_flat), 0);
        item_present = 1'b0;
        color_done = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_busy", int'(busy), 0);

        // 17 red items: wrap or saturate
        for (int i = 1; i <= 17; i++) begin
`ifdef SORT_SAT_COUNT_EN
            exp_n = (i > 15) ? 15 : i;
`else
            exp_n = i % 16;
`endif
            red = '{3'd0, 1, 0, 0, exp_n, exp_n};
            run_item(red, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sort_sequencer.md
Name: sort_sequencer

Overview:
- Top-level scheduler for one item's colour test and sort. Detects an item at the sensor, waits for it to settle, then runs the colour-measurement block: raises its run request, waits for its done, latches its 3-bit colour code.
- Routes the item by selecting a bin and pulsing the sort gate for a fixed time.
- Keeps sort statistics. Sits between the item sensor/gate actuator and the colour-measurement block.

Parameters:
- SETTLE_CYCLES, 1000: cycles item_present must stay high before measurement starts.
- TIMEOUT_CYCLES, 4000000: maximum cycles in MEASURE waiting for color_done.
- GATE_CYCLES, 500000: cycles gate_open is held high.
- CNT_W, 8: width of each statistics counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- item_present  in  1  item at sensor, level; synchronised internally with a 2-flop synchroniser.
- color_done  in  1  measurement complete, level, from colour block.
- color_code  in  3  0=red 1=blue 2=green 3=yellow 4=unknown; 5-7 are treated as unknown.
- color_run  out  1  run request to colour block; low also clears that block.
- bin_sel  out  3  bin index for current item.
- gate_open  out  1  gate actuator drive.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky flag; set on measurement timeout, cleared by reset only.
- total_count  out  CNT_W  items sorted.
- count_flat  out  5*CNT_W  per-colour counts, colour k at [k*CNT_W +: CNT_W].

Behaviour:
- Reset (rst_n low at posedge) drives all outputs to zero, state to IDLE, and clears all timers and counters. Reset mid-operation aborts immediately: color_run and gate_open fall on the next edge.
- States:
  - IDLE: wait for synchronised item_present=1, then go to SETTLE and clear the timer.
  - SETTLE: if item_present drops, return to IDLE. If the timer reaches SETTLE_CYCLES-1 with item_present still high, go to MEASURE.
  - MEASURE: color_run=1.
    - color_done=1: latch color_code (values >4 map to 4), go to ROUTE.
    - Timer reaches TIMEOUT_CYCLES-1 without done: set timeout_err, latch code 4, go to ROUTE.
    - color_done and timeout on the same cycle: done wins, timeout_err is not set.
  - ROUTE: color_run=0; bin_sel=latched code; gate_open=1 for exactly GATE_CYCLES cycles.
    - On the last cycle, increment total_count and the counter for the latched code, then go to RELEASE.
  - RELEASE: gate_open=0, bin_sel held. Wait until item_present=0 and color_done=0 (the colour block has cleared), then go to IDLE.
- Latencies:
  - color_run rises SETTLE_CYCLES+1 cycles after the synchronised item_present rises.
  - gate_open rises 1 cycle after color_done is sampled.
- Counters wrap modulo 2^CNT_W (default build).
- A single timer of width clog2(max param) is shared by all states and cleared on every state transition.
- color_done is ignored outside MEASURE.

Optional Feature:
- SORT_SAT_COUNT_EN:
  - Defined: total_count and all per-colour counters saturate at 2^CNT_W-1 instead of wrapping.
  - Undefined: counters wrap.

Decomposition:
- Package sort_pkg holds:
  - colour code localparams COL_RED=0, COL_BLUE=1, COL_GREEN=2, COL_YELLOW=3, COL_UNKNOWN=4 and NUM_COLOURS=5;
  - the state enum {IDLE, SETTLE, MEASURE, ROUTE, RELEASE}, encoded in 3 bits.
- One sub-module, sort_stats: counter bank with inc strobe, colour index, and the saturate option. The FSM and timer stay in sort_sequencer.

Test Plan (SETTLE=4, TIMEOUT=20, GATE=3, CNT_W=4):
- Item high 10 cycles, color_done high with code 2 at cycle 5 of MEASURE -> bin_sel=2, gate_open high 3 cycles, green count=1, total=1, timeout_err=0.
- Item glitch high for 2 cycles only -> stays IDLE, color_run never rises, busy returns 0.
- No color_done -> color_run high 20 cycles, timeout_err=1, bin_sel=4, unknown count=1.
- color_code=6 with done -> routed as 4, unknown count increments.
- rst_n low mid-ROUTE -> next edge: gate_open=0, busy=0, counters 0, state IDLE.
- 17 red items -> default build: red count=1 (wrapped). SORT_SAT_COUNT_EN defined: red count=15, total=15.
